z80_mem_read_cycle: RTL and testbench
=====================================

// Module: z80_mem_read_cycle
// PURPOSE
//  Bus-side sequencer for the Z80 memory-read machine cycles. It is the read
//  counterpart to the memory-write path that LD (HL),n exercises. On request it
//  runs either a plain memory read (T1-T3) or an opcode fetch (M1: T1-T4 with
//  refresh), inserting wait states on bus_wait_n. It returns the sampled byte to
//  the core and reports it via done.
//  clk runs at 2x the T-state rate: each T-state is an H half (clk 1) then an
//  L half (clk 2). This lets falling-edge Z80 events land on clk rising edges.
// PARAMETERS
//  WAIT_LIMIT  0  max wait T-states per cycle; 0 = unlimited; on overflow force T3 and flag timeout
// PORTS
//  clk           in   1   clock (2x T-state rate)
//  reset         in   1   asynchronous, active-high reset
//  start         in   1   request a cycle; sampled only in IDLE
//  m1_mode       in   1   1 = opcode fetch (M1), 0 = memory read; latched with start
//  addr          in   16  read address; latched with start
//  refresh_addr  in   16  {I,R} refresh address; latched with start
//  busy          out  1   high from the clk after start acceptance until return to IDLE
//  done          out  1   one-clk pulse; rdata valid while high
//  rdata         out  8   sampled byte; holds until next capture
//  timeout       out  1   qualifies done: WAIT_LIMIT overflowed in this cycle
//  bus_addr      out  16  address bus
//  bus_mreq_n    out  1   memory request, active low
//  bus_rd_n      out  1   read strobe, active low
//  bus_m1_n      out  1   M1 marker, active low
//  bus_rfsh_n    out  1   refresh marker, active low
//  bus_wait_n    in   1   wait request, active low
//  bus_data_in   in   8   data bus input
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; strobes *_n=1; bus_addr=0; busy=done=timeout=0; rdata=0.
//  All outputs are registered. Reset mid-cycle deasserts every strobe at once and discards the capture.
//  States: IDLE,T1H,T1L,T2H,T2L,TWH,TWL,T3H,T3L,T4H,T4L. One state per clk.
//  IDLE: if start, latch addr/refresh_addr/m1_mode, go to T1H. Otherwise stay.
//  T1H: bus_addr=addr; bus_m1_n=!m1_mode.
//  T1L: bus_mreq_n=0, bus_rd_n=0.
//  T2H -> T2L.
//  End of T2L / TWL: sample bus_wait_n.
//   - 0 -> TWH (wait count +1).
//   - 1 -> T3H.
//   - If count == WAIT_LIMIT != 0, go to T3H and set timeout.
//  Read (m1_mode=0):
//   - T3H: strobes held.
//   - Exit T3H: capture bus_data_in -> rdata.
//   - T3L: mreq_n=rd_n=1.
//   - After T3L -> IDLE with done=1.
//  M1 (m1_mode=1):
//   - Exit T2L/TWL to T3H: capture bus_data_in.
//   - T3H: mreq_n=rd_n=m1_n=1, rfsh_n=0, bus_addr=refresh_addr.
//   - T3L, T4H: mreq_n=0.
//   - T4L: mreq_n=1.
//   - After T4L -> IDLE with done=1, rfsh_n=1.
//  Latency with zero waits, start accepted at clk 0:
//   - Read: done at clk 7.
//   - M1: done at clk 9.
//   - Each wait state adds 2 clk.
//  done: high exactly 1 clk, in IDLE. start in that same clk is accepted (back-to-back, no gap).
//  start while busy is ignored, not queued.
//  bus_wait_n is ignored outside T2L/TWL.
//  timeout clears on the next start acceptance.
//  bus_addr holds its last value in IDLE.
// TESTING
//  Read 0x1234, wait_n=1, data=0xA5:
//   - mreq_n/rd_n low clk 2-6; done at clk 7.
//   - rdata=0xA5, timeout=0.
//  M1 at 0x0100, refresh_addr=0x3F7E, data=0xC3:
//   - m1_n low clk 1-4; rfsh_n low clk 5-8.
//   - mreq_n low clk 2-4 and 6-7.
//   - bus_addr=0x3F7E from clk 5; done at clk 9 with rdata=0xC3.
//  Read with wait_n=0 for 2 samples: done at clk 11; data is taken from the T3H exit only.
//  WAIT_LIMIT=3, wait_n held 0: done at clk 13 with timeout=1.
//  start asserted in done clk: next T1H follows immediately with no idle clk; start while busy is ignored.
//  reset asserted during T2H of an M1 cycle:
//   - All strobes go to 1 asynchronously; busy=0, rdata=0.
//   - The next start runs cleanly.

Source files
------------

// File: rtl/z80_mem_read_cycle.sv
// Z80 memory-read / opcode-fetch bus sequencer.
// clk runs at twice the T-state rate: one state per half T-state.
module z80_mem_read_cycle #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        m1_mode,
  input  logic [15:0] addr,
  input  logic [15:0] refresh_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  output logic [15:0] bus_addr,
  output logic        bus_mreq_n,
  output logic        bus_rd_n,
  output logic        bus_m1_n,
  output logic        bus_rfsh_n,
  input  logic        bus_wait_n,
  input  logic [7:0]  bus_data_in
);

  localparam int CW = 16;

  typedef enum logic [3:0] {
    IDLE, T1H, T1L, T2H, T2L, TWH,
    TWL, T3H, T3L, T4H, T4L
  } state_t;

  state_t state, state_d;

  logic          m1_q, m1_d;
  logic [15:0]   rfsh_q, rfsh_d;
  logic [CW-1:0] wcnt, wcnt_d;
  logic          limit_hit;

  logic          busy_d, done_d, to_d;
  logic          mreq_d, rd_d, m1n_d, rfshn_d;
  logic [7:0]    rdata_d;
  logic [15:0]   addr_d;

  assign limit_hit = (WAIT_LIMIT != 0) &&
                     (wcnt == CW'(WAIT_LIMIT));

  // Outputs are computed for the state being
  // entered, so every bus pin comes from a flop.
  always_comb begin
    state_d = state;
    m1_d    = m1_q;
    rfsh_d  = rfsh_q;
    wcnt_d  = wcnt;
    done_d  = 1'b0;
    to_d    = timeout;
    mreq_d  = bus_mreq_n;
    rd_d    = bus_rd_n;
    m1n_d   = bus_m1_n;
    rfshn_d = bus_rfsh_n;
    rdata_d = rdata;
    addr_d  = bus_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = T1H;
          m1_d    = m1_mode;
          rfsh_d  = refresh_addr;
          wcnt_d  = '0;
          to_d    = 1'b0;
          addr_d  = addr;
          m1n_d   = !m1_mode;
        end
      end
      T1H: begin
        state_d = T1L;
        mreq_d  = 1'b0;
        rd_d    = 1'b0;
      end
      T1L: state_d = T2H;
      T2H: state_d = T2L;
      T2L, TWL: begin
        if (!bus_wait_n && !limit_hit) begin
          state_d = TWH;
          wcnt_d  = wcnt + CW'(1);
        end else begin
          state_d = T3H;
          to_d    = !bus_wait_n;
          if (m1_q) begin
            rdata_d = bus_data_in;
            mreq_d  = 1'b1;
            rd_d    = 1'b1;
            m1n_d   = 1'b1;
            rfshn_d = 1'b0;
            addr_d  = rfsh_q;
          end
        end
      end
      TWH: state_d = TWL;
      T3H: begin
        state_d = T3L;
        if (m1_q) mreq_d = 1'b0;
        else rdata_d = bus_data_in;
      end
      T3L: begin
        if (m1_q) begin
          state_d = T4H;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          mreq_d  = 1'b1;
          rd_d    = 1'b1;
        end
      end
      T4H: begin
        state_d = T4L;
        mreq_d  = 1'b1;
      end
      T4L: begin
        state_d = IDLE;
        done_d  = 1'b1;
        rfshn_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      m1_q       <= 1'b0;
      rfsh_q     <= '0;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rdata      <= '0;
      bus_addr   <= '0;
      bus_mreq_n <= 1'b1;
      bus_rd_n   <= 1'b1;
      bus_m1_n   <= 1'b1;
      bus_rfsh_n <= 1'b1;
    end else begin
      state      <= state_d;
      m1_q       <= m1_d;
      rfsh_q     <= rfsh_d;
      wcnt       <= wcnt_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= to_d;
      rdata      <= rdata_d;
      bus_addr   <= addr_d;
      bus_mreq_n <= mreq_d;
      bus_rd_n   <= rd_d;
      bus_m1_n   <= m1n_d;
      bus_rfsh_n <= rfshn_d;
    end
  end

endmodule

// File: tb/tb_z80_mem_read_cycle.sv
// Bench for z80_mem_read_cycle: unlimited and
// WAIT_LIMIT=3 instances share one stimulus.
module tb_z80_mem_read_cycle;

  typedef struct {
    logic [7:0] d;
    logic       to;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, m1_mode;
  logic        bus_wait_n;
  logic [15:0] addr, refresh_addr;
  logic [7:0]  bus_data_in;

  logic        busy [2];
  logic        done [2];
  logic        timeout [2];
  logic        mreq_n [2];
  logic        rd_n [2];
  logic        m1_n [2];
  logic        rfsh_n [2];
  logic [7:0]  rdata [2];
  logic [15:0] bus_addr [2];

  int   checks = 0;
  int   failures = 0;
  int   kc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  z80_mem_read_cycle #(.WAIT_LIMIT(0)) dut (
    .clk(clk), .reset(reset),
    .start(start), .m1_mode(m1_mode),
    .addr(addr), .refresh_addr(refresh_addr),
    .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .timeout(timeout[0]),
    .bus_addr(bus_addr[0]),
    .bus_mreq_n(mreq_n[0]), .bus_rd_n(rd_n[0]),
    .bus_m1_n(m1_n[0]), .bus_rfsh_n(rfsh_n[0]),
    .bus_wait_n(bus_wait_n),
    .bus_data_in(bus_data_in)
  );

  z80_mem_read_cycle #(.WAIT_LIMIT(3)) dut_lim (
    .clk(clk), .reset(reset),
    .start(start), .m1_mode(m1_mode),
    .addr(addr), .refresh_addr(refresh_addr),
    .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .timeout(timeout[1]),
    .bus_addr(bus_addr[1]),
    .bus_mreq_n(mreq_n[1]), .bus_rd_n(rd_n[1]),
    .bus_m1_n(m1_n[1]), .bus_rfsh_n(rfsh_n[1]),
    .bus_wait_n(bus_wait_n),
    .bus_data_in(bus_data_in)
  );

  // Scoreboard: done must appear exactly at the
  // queued cycle, with the queued data/timeout.
  always @(negedge clk) begin
    exp_t e;
    logic ed;
    for (int i = 0; i < 2; i++) begin
      ed = 1'b0;
      e  = exp_t'{8'h00, 1'b0, 0};
      if (i == 0 && q0.size() > 0 && q0[0].lat == kc) begin
        ed = 1'b1;
        e  = q0.pop_front();
      end
      if (i == 1 && q1.size() > 0 && q1[0].lat == kc) begin
        ed = 1'b1;
        e  = q1.pop_front();
      end
      checks++;
      if (done[i] !== ed) begin
        failures++;
        $display("FAIL done[%0d] k=%0d got %b want %b",
                 i, kc, done[i], ed);
      end
      if (ed) begin
        checks += 2;
        if (rdata[i] !== e.d) begin
          failures++;
          $display("FAIL rdata[%0d] k=%0d got %h want %h",
                   i, kc, rdata[i], e.d);
        end
        if (timeout[i] !== e.to) begin
          failures++;
          $display("FAIL timeout[%0d] k=%0d got %b want %b",
                   i, kc, timeout[i], e.to);
        end
      end
    end
  end

  task automatic test_reset();
    logic [6:0] g;
    reset = 1'b1;
    start = 1'b1;
    m1_mode = 1'b1;
    addr = 16'hFFFF;
    refresh_addr = 16'hFFFF;
    bus_wait_n = 1'b1;
    bus_data_in = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i],
             busy[i], done[i], timeout[i]};
        checks++;
        if (g !== 7'b1111000 || rdata[i] !== 8'h00 ||
            bus_addr[i] !== 16'h0000) begin
          failures++;
          $display("FAIL reset[%0d] got %b/%h/%h want 1111000/00/0000",
                   i, g, rdata[i], bus_addr[i]);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read(input logic [15:0] a,
                           input logic [7:0] d);
    logic [4:0] g, x;
    q0.push_back(exp_t'{d, 1'b0, 7});
    q1.push_back(exp_t'{d, 1'b0, 7});
    for (int k = 0; k <= 8; k++) begin
      kc = k;
      start = (k == 0);
      m1_mode = 1'b0;
      addr = a;
      refresh_addr = ~a;
      bus_data_in = (k == 5) ? d : ~d;
      bus_wait_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i], busy[i]};
        x = {!(k >= 2 && k <= 6), !(k >= 2 && k <= 6),
             1'b1, 1'b1, (k >= 1 && k <= 6)};
        checks++;
        if (g !== x) begin
          failures++;
          $display("FAIL read strobes[%0d] k=%0d got %b want %b",
                   i, k, g, x);
        end
        if (k >= 1) begin
          checks++;
          if (bus_addr[i] !== a) begin
            failures++;
            $display("FAIL read addr[%0d] k=%0d got %h want %h",
                     i, k, bus_addr[i], a);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_m1();
    logic [4:0]  g, x;
    logic [15:0] xa;
    q0.push_back(exp_t'{8'hC3, 1'b0, 9});
    q1.push_back(exp_t'{8'hC3, 1'b0, 9});
    for (int k = 0; k <= 10; k++) begin
      kc = k;
      start = (k == 0);
      m1_mode = 1'b1;
      addr = 16'h0100;
      refresh_addr = 16'h3F7E;
      bus_data_in = (k == 4) ? 8'hC3 : 8'h3C;
      bus_wait_n = 1'b1;
      @(negedge clk);
      xa = (k >= 5) ? 16'h3F7E : 16'h0100;
      for (int i = 0; i < 2; i++) begin
        g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i], busy[i]};
        x = {!(k inside {2, 3, 4, 6, 7}),
             !(k >= 2 && k <= 4), !(k >= 1 && k <= 4),
             !(k >= 5 && k <= 8), (k >= 1 && k <= 8)};
        checks++;
        if (g !== x) begin
          failures++;
          $display("FAIL m1 strobes[%0d] k=%0d got %b want %b",
                   i, k, g, x);
        end
        if (k >= 1) begin
          checks++;
          if (bus_addr[i] !== xa) begin
            failures++;
            $display("FAIL m1 addr[%0d] k=%0d got %h want %h",
                     i, k, bus_addr[i], xa);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waits();
    logic [4:0] g, x;
    q0.push_back(exp_t'{8'h5A, 1'b0, 11});
    q1.push_back(exp_t'{8'h5A, 1'b0, 11});
    for (int k = 0; k <= 12; k++) begin
      kc = k;
      start = (k == 0);
      m1_mode = 1'b0;
      addr = 16'h4321;
      refresh_addr = 16'h0000;
      bus_data_in = (k == 9) ? 8'h5A : 8'h00;
      bus_wait_n = (k == 4 || k == 6 || k >= 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i], busy[i]};
        x = {!(k >= 2 && k <= 10), !(k >= 2 && k <= 10),
             1'b1, 1'b1, (k >= 1 && k <= 10)};
        checks++;
        if (g !== x) begin
          failures++;
          $display("FAIL waits strobes[%0d] k=%0d got %b want %b",
                   i, k, g, x);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [4:0] g, x;
    int last;
    q0.push_back(exp_t'{8'h77, 1'b0, 17});
    q1.push_back(exp_t'{8'h77, 1'b1, 13});
    for (int k = 0; k <= 18; k++) begin
      kc = k;
      start = (k == 0);
      m1_mode = 1'b0;
      addr = 16'h0F0F;
      refresh_addr = 16'h0000;
      bus_data_in = 8'h77;
      bus_wait_n = (k >= 14);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        last = (i == 0) ? 16 : 12;
        g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i], busy[i]};
        x = {!(k >= 2 && k <= last), !(k >= 2 && k <= last),
             1'b1, 1'b1, (k >= 1 && k <= last)};
        checks++;
        if (g !== x) begin
          failures++;
          $display("FAIL timeout strobes[%0d] k=%0d got %b want %b",
                   i, k, g, x);
        end
      end
      if (k == 18) begin
        checks++;
        if (timeout[1] !== 1'b1) begin
          failures++;
          $display("FAIL timeout hold got %b want 1",
                   timeout[1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  g, x;
    logic [15:0] xa;
    q0.push_back(exp_t'{8'h11, 1'b0, 7});
    q1.push_back(exp_t'{8'h11, 1'b0, 7});
    q0.push_back(exp_t'{8'h22, 1'b0, 14});
    q1.push_back(exp_t'{8'h22, 1'b0, 14});
    for (int k = 0; k <= 15; k++) begin
      kc = k;
      start = (k == 0 || k == 3 || k == 7);
      m1_mode = (k == 3);
      addr = (k == 0) ? 16'h2000 :
             (k == 7) ? 16'h3000 : 16'hDEAD;
      refresh_addr = 16'hBEEF;
      bus_data_in = (k < 7) ? 8'h11 : 8'h22;
      bus_wait_n = 1'b1;
      @(negedge clk);
      xa = (k >= 8) ? 16'h3000 : 16'h2000;
      for (int i = 0; i < 2; i++) begin
        g = {m1_n[i], busy[i]};
        x = {1'b1, ((k >= 1 && k <= 6) || (k >= 8 && k <= 13))};
        checks++;
        if (g !== x) begin
          failures++;
          $display("FAIL b2b m1n/busy[%0d] k=%0d got %b want %b",
                   i, k, g, x);
        end
        if (k >= 1) begin
          checks++;
          if (bus_addr[i] !== xa) begin
            failures++;
            $display("FAIL b2b addr[%0d] k=%0d got %h want %h",
                     i, k, bus_addr[i], xa);
          end
        end
      end
      if (k == 1) begin
        checks++;
        if (timeout[1] !== 1'b0) begin
          failures++;
          $display("FAIL timeout clear got %b want 0",
                   timeout[1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] g;
    for (int k = 0; k <= 2; k++) begin
      kc = k;
      start = (k == 0);
      m1_mode = 1'b1;
      addr = 16'h0200;
      refresh_addr = 16'h1111;
      bus_data_in = 8'h99;
      bus_wait_n = 1'b1;
      @(negedge clk);
      if (k >= 1) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (m1_n[i] !== 1'b0) begin
            failures++;
            $display("FAIL pre-reset m1_n[%0d] k=%0d got %b want 0",
                     i, k, m1_n[i]);
          end
        end
      end
      @(posedge clk); #1;
    end
    kc = 3;
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      g = {mreq_n[i], rd_n[i], m1_n[i], rfsh_n[i],
           busy[i], done[i], timeout[i]};
      checks++;
      if (g !== 7'b1111000 || rdata[i] !== 8'h00 ||
          bus_addr[i] !== 16'h0000) begin
        failures++;
        $display("FAIL mid reset[%0d] got %b/%h/%h want 1111000/00/0000",
                 i, g, rdata[i], bus_addr[i]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read(16'h1234, 8'hA5);
    test_m1();
    test_waits();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_read(16'hBEEF, 8'h3C);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
